// File: rtl/secded16_encoder_pipe.sv
// secded16_encoder_pipe
// Two-stage pipelined SEC/DED encoder for 16-bit data words. It produces a
// 22-bit extended-Hamming codeword with 5 check bits at positions 1, 2, 4, 8
// and 16, and an overall even-parity bit in bit 0. A test-only mask can be
// XORed onto the codeword so that the downstream checker can be exercised.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input word valid
//   in_ready   encoder can take a word this cycle (combinational from out_ready)
//   in_data    16-bit data word, bit 0 is d0
//   inj_mask   22-bit error-injection mask, sampled with in_data
//   inj_en     enables inj_mask; when low the mask is treated as zero
//   out_valid  codeword valid
//   out_ready  downstream accepts the codeword
//   out_code   22-bit codeword after error injection
//   out_inj    presented codeword carries a nonzero injected mask
//   word_cnt   saturating count of codewords accepted downstream
//   cnt_clr    synchronous clear of word_cnt, wins over an increment
module secded16_encoder_pipe #(
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [21:0]      inj_mask,
    input  logic             inj_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [21:0]      out_code,
    output logic             out_inj,
    output logic [CNT_W-1:0] word_cnt,
    input  logic             cnt_clr
);

    // Only the two-stage arrangement is implemented.
    if (PIPE_STAGES != 2) begin : g_unsupported_stages
        $error("secded16_encoder_pipe supports PIPE_STAGES == 2 only");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Extended-Hamming encode. Data bits fill the non-power-of-two positions;
    // each check mask selects the positions whose index has bit k set. The
    // masks are applied to the data-only word, so check positions read as 0.
    function automatic logic [21:0] secded_encode(input logic [15:0] d);
        logic [21:0] data_w;
        logic [21:0] code_w;
        data_w     = 22'd0;
        data_w[3]  = d[0];
        data_w[5]  = d[1];
        data_w[6]  = d[2];
        data_w[7]  = d[3];
        data_w[9]  = d[4];
        data_w[10] = d[5];
        data_w[11] = d[6];
        data_w[12] = d[7];
        data_w[13] = d[8];
        data_w[14] = d[9];
        data_w[15] = d[10];
        data_w[17] = d[11];
        data_w[18] = d[12];
        data_w[19] = d[13];
        data_w[20] = d[14];
        data_w[21] = d[15];
        code_w     = data_w;
        code_w[1]  = ^(data_w & 22'h2AAAAA);
        code_w[2]  = ^(data_w & 22'h0CCCCC);
        code_w[4]  = ^(data_w & 22'h30F0F0);
        code_w[8]  = ^(data_w & 22'h00FF00);
        code_w[16] = ^(data_w & 22'h3F0000);
        // Overall parity makes the complete 22-bit word even.
        code_w[0]  = ^code_w[21:1];
        return code_w;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [15:0]      s1_data_q,  s1_data_d;
    logic [21:0]      s1_mask_q,  s1_mask_d;
    logic             s2_valid_q, s2_valid_d;
    logic [21:0]      s2_code_q,  s2_code_d;
    logic             s2_inj_q,   s2_inj_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic in_fire;
    logic out_fire;
    logic s1_adv;

    // Handshake qualifiers shared by both stages.
    always_comb begin
        in_ready = (~s1_valid_q) | (~s2_valid_q) | out_ready;
        in_fire  = in_valid & in_ready;
        out_fire = s2_valid_q & out_ready;
        s1_adv   = s1_valid_q & ((~s2_valid_q) | out_ready);
    end

    // Stage 1: capture the data word and the effective injection mask.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mask_d  = s1_mask_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_data;
            s1_mask_d  = inj_en ? inj_mask : 22'd0;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2: encode, apply the mask, hold while downstream stalls.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_code_d  = s2_code_q;
        s2_inj_d   = s2_inj_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_code_d  = secded_encode(s1_data_q) ^ s1_mask_q;
            s2_inj_d   = |s1_mask_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Saturating transfer counter; clear beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (out_fire && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= 16'd0;
            s1_mask_q  <= 22'd0;
            s2_valid_q <= 1'b0;
            s2_code_q  <= 22'd0;
            s2_inj_q   <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mask_q  <= s1_mask_d;
            s2_valid_q <= s2_valid_d;
            s2_code_q  <= s2_code_d;
            s2_inj_q   <= s2_inj_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_code  = s2_code_q;
    assign out_inj   = s2_inj_q;
    assign word_cnt  = cnt_q;

endmodule
